div_secuencial: RTL and testbench
=================================

# div_secuencial

Multi-cycle 32-bit integer divider for the RV32M DIVU/REMU (and optionally DIV/REM) operations of the core. It sequences one shared `fn_suma_resta` instance in subtract mode, one restoring-division step per clock, 32 steps per operation. It sits beside the single-cycle ALU in the execute stage. The pipeline stalls on `ocupado` and captures results on `listo`.

## Interface
- Parameter `N_ITER`, default 32: iteration count. Fixed to the operand width and not overridable in RV32I builds.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inicio` in 1: start request, sampled only in REPOSO.
- `con_signo` in 1: 1 = DIV/REM semantics. Ignored (treated as 0) unless `DIV_SIGNO_EN` is defined.
- `dividendo` in 32: dividend, sampled with `inicio`.
- `divisor` in 32: divisor, sampled with `inicio`.
- `ocupado` out 1: operation in progress.
- `listo` out 1: one-cycle pulse; `cociente`/`resto` valid.
- `cociente` out 32: quotient, held until the next accepted `inicio`.
- `resto` out 32: remainder, held until the next accepted `inicio`.

## Operation
- States and transitions:
  - REPOSO: `inicio`=1 and divisor≠0 → CALCULO; `inicio`=1 and divisor=0 → FIN.
  - CALCULO: → FIN after 32 steps.
  - FIN: → REPOSO unconditionally.
- Load (REPOSO edge with `inicio`):
  - R←0, Q←|dividendo|, D←|divisor|, contador←0.
  - Save the sign flags when signed.
  - Unsigned mode takes operands unchanged.
- Each CALCULO step:
  - {R',Q'} = {R,Q}<<1.
  - T = R' − D via `fn_suma_resta` (a=R', b=D, resta=1).
  - The step succeeds if old R[31]=1 (the true 33-bit value exceeds D) or R' ≥ D unsigned.
  - On success: R←T, Q←Q'|1. Otherwise: R←R', Q←Q'.
  - contador increments 0..31. The transition to FIN occurs on the edge where contador=31.
- Division by zero (RISC-V semantics): cociente=0xFFFFFFFF, resto=dividendo (original, unsigned view). No iterations are run.
- Register a result only on entry to FIN. In FIN, `listo`=1 for exactly one cycle.
- `inicio` while `ocupado`=1 or in FIN is ignored; no queuing.
- Reset, including mid-operation, forces REPOSO, contador=0, `ocupado`=0, `listo`=0, `cociente`=0, `resto`=0. The partial operation is discarded.
- All arithmetic is modulo 2^32. No exceptions or flags are produced.

## Timing
- `inicio` is accepted at edge T.
- Normal operation:
  - `ocupado`=1 during cycles T+1..T+32.
  - At T+33: `listo`=1, `ocupado`=0, results valid.
  - The next `inicio` is accepted no earlier than the edge ending cycle T+33 (FIN→REPOSO), effective T+34.
- Divide by zero: `listo`=1 in cycle T+1, `ocupado` never asserts.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Configuration
- Macro `DIV_SIGNO_EN`.
- Defined:
  - `con_signo` selects signed mode.
  - Operand magnitudes are taken at load.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend. Both corrections apply on the FIN-entry edge.
  - Overflow 0x80000000 / 0xFFFFFFFF → cociente=0x80000000, resto=0. This falls out of the magnitude path and needs no special case, but must be verified.
  - Signed divide by zero gives cociente=0xFFFFFFFF, resto=dividendo.
- Not defined: no sign logic is synthesized and all divisions are unsigned.
- Latency is identical in both builds.

## Structure
- Shared package/include `rv32_pkg`:
  - State encoding localparams REPOSO=2'd0, CALCULO=2'd1, FIN=2'd2.
  - `XLEN`=32.
  - `COCIENTE_DIV0`=32'hFFFFFFFF.
- Sub-module: one instance of the existing `fn_suma_resta` for the trial subtraction, with `resta` tied to 1.
- Operand/result negation uses separate inline two's-complement logic, so the adder is not time-shared.

## Test plan
- 100 / 7 unsigned, `inicio` at T → `listo` at T+33 with cociente=14, resto=2; `ocupado` high for exactly 32 cycles.
- 0xFFFFFFFF / 1 → cociente=0xFFFFFFFF, resto=0. Also 0xFFFFFFFF / 0x80000001 → cociente=1, resto=0x7FFFFFFE; this exercises the R[31] path.
- 5 / 0 → `listo` at T+1, cociente=0xFFFFFFFF, resto=5, `ocupado` stays 0.
- Busy and reset handling:
  - Start 1000/3, pulse `inicio` with 9/3 at T+10 → result 333 rem 1 at T+33; the second request is ignored.
  - Separately, assert `reset` at T+15 → all outputs 0, REPOSO next cycle. A fresh 9/3 then gives 3 rem 0.
- With `DIV_SIGNO_EN`:
  - −7/2 → cociente=−3 (0xFFFFFFFD), resto=−1.
  - 7/−2 → −3, 1.
  - 0x80000000/0xFFFFFFFF → 0x80000000, 0.
- Without `DIV_SIGNO_EN`: 0xFFFFFFF9/2 with `con_signo`=1 → 0x7FFFFFFC, 1.

Source files
------------

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32 definitions for the execute stage: operand width,
//               divider state encoding, divide-by-zero quotient and a
//               two's-complement helper used by the optional signed path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Architectural operand width
  localparam int XLEN = 32;

  // Quotient returned for any division by zero (RISC-V semantics)
  localparam logic [XLEN-1:0] COCIENTE_DIV0 = 32'hFFFF_FFFF;

  // Divider state encoding
  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] CALCULO = 2'd1;
  localparam logic [1:0] FIN     = 2'd2;

  typedef enum logic [1:0] {
    ST_REPOSO  = REPOSO,
    ST_CALCULO = CALCULO,
    ST_FIN     = FIN
  } div_estado_t;

  // Two's-complement negation, kept apart from the shared subtractor
  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
    return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/fn_suma_resta.sv
`default_nettype none
// ============================================================================
// Module      : fn_suma_resta
// Description : W-bit adder/subtractor. With resta=1 it computes a - b as
//               a + ~b + 1; cout is then the "no borrow" flag (a >= b).
// Revision    : 1.0 - initial release
// ============================================================================
module fn_suma_resta #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         resta,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] w_b_ef;
  logic [W:0]   w_suma;

  // Conditionally invert b and inject the carry-in for subtraction
  assign w_b_ef = b ^ {W{resta}};
  assign w_suma = {1'b0, a} + {1'b0, w_b_ef} + {{W{1'b0}}, resta};
  assign s      = w_suma[W-1:0];
  assign cout   = w_suma[W];

endmodule : fn_suma_resta
`default_nettype wire

// File: rtl/div_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : div_secuencial
// Description : Multi-cycle restoring divider for RV32M DIVU/REMU, one step
//               per clock over N_ITER steps, using one shared fn_suma_resta
//               in subtract mode. Divide by zero completes in one cycle.
//               Optional macro DIV_SIGNO_EN adds DIV/REM (signed) support via
//               magnitude division plus sign correction at FIN entry.
// Revision    : 1.0 - initial release
// ============================================================================
module div_secuencial
  import rv32_pkg::*;
#(
  // Tied to the operand width; the counter and shift path assume N_ITER == XLEN
  parameter int N_ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inicio,
  input  logic            con_signo,
  input  logic [XLEN-1:0] dividendo,
  input  logic [XLEN-1:0] divisor,
  output logic            ocupado,
  output logic            listo,
  output logic [XLEN-1:0] cociente,
  output logic [XLEN-1:0] resto
);

  localparam int CW = $clog2(N_ITER);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  div_estado_t     r_estado;
  div_estado_t     w_estado_sig;

  logic [CW-1:0]   r_cont;
  logic [XLEN-1:0] r_rem;      // partial remainder R
  logic [XLEN-1:0] r_quo;      // shifting dividend / quotient Q
  logic [XLEN-1:0] r_dvs;      // divisor magnitude D

  logic            w_acepta;   // start request taken this cycle
  logic            w_div0;
  logic            w_ultimo;   // current step is the last one

  logic [XLEN-1:0] w_mag_a;    // dividend as loaded into Q
  logic [XLEN-1:0] w_mag_b;    // divisor as loaded into D

  logic [XLEN-1:0] w_r_sh;     // R' = {R,Q} << 1, upper half
  logic [XLEN-1:0] w_q_sh;     // Q' = {R,Q} << 1, lower half
  logic [XLEN-1:0] w_t;        // R' - D
  logic            w_cout;     // R' >= D (no borrow)
  logic            w_ok;       // step succeeds
  logic [XLEN-1:0] w_rem_sig;
  logic [XLEN-1:0] w_quo_sig;

  logic [XLEN-1:0] w_q_fin;    // quotient after sign correction
  logic [XLEN-1:0] w_r_fin;    // remainder after sign correction

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  assign w_acepta = (r_estado == ST_REPOSO) && inicio;
  assign w_div0   = (divisor == '0);
  assign w_ultimo = (r_cont == CW'(N_ITER - 1));

  // --------------------------------------------------------------------------
  // Operand conditioning and result sign correction
  // --------------------------------------------------------------------------
`ifdef DIV_SIGNO_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg_q;
  logic r_neg_r;

  assign w_neg_a = con_signo & dividendo[XLEN-1];
  assign w_neg_b = con_signo & divisor[XLEN-1];
  assign w_mag_a = w_neg_a ? neg2c(dividendo) : dividendo;
  assign w_mag_b = w_neg_b ? neg2c(divisor)   : divisor;

  // Quotient negated when signs differ; remainder follows the dividend sign
  assign w_q_fin = r_neg_q ? neg2c(w_quo_sig) : w_quo_sig;
  assign w_r_fin = r_neg_r ? neg2c(w_rem_sig) : w_rem_sig;

  // Capture the sign flags together with the operand magnitudes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_acepta) begin
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
    end
  end
`else
  // Unsigned-only build: con_signo has no effect
  logic w_unused_signo;

  assign w_unused_signo = con_signo;
  assign w_mag_a        = dividendo;
  assign w_mag_b        = divisor;
  assign w_q_fin        = w_quo_sig;
  assign w_r_fin        = w_rem_sig;
`endif

  // --------------------------------------------------------------------------
  // One restoring-division step
  // --------------------------------------------------------------------------
  assign w_r_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_q_sh = {r_quo[XLEN-2:0], 1'b0};

  fn_suma_resta #(
    .W (XLEN)
  ) u_suma_resta (
    .a     (w_r_sh),
    .b     (r_dvs),
    .resta (1'b1),
    .s     (w_t),
    .cout  (w_cout)
  );

  // A set R[31] means the shifted remainder is a 33-bit value above D
  assign w_ok      = r_rem[XLEN-1] | w_cout;
  assign w_rem_sig = w_ok ? w_t : w_r_sh;
  assign w_quo_sig = w_q_sh | {{(XLEN-1){1'b0}}, w_ok};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= ST_REPOSO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next-state and status decode; status depends on state only
  always_comb begin
    w_estado_sig = r_estado;
    ocupado      = 1'b0;
    listo        = 1'b0;
    case (r_estado)
      ST_REPOSO: begin
        if (inicio) begin
          w_estado_sig = w_div0 ? ST_FIN : ST_CALCULO;
        end
      end
      ST_CALCULO: begin
        ocupado = 1'b1;
        if (w_ultimo) begin
          w_estado_sig = ST_FIN;
        end
      end
      ST_FIN: begin
        listo        = 1'b1;
        w_estado_sig = ST_REPOSO;
      end
      default: begin
        w_estado_sig = ST_REPOSO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers and result capture on FIN entry
  // --------------------------------------------------------------------------

  // Load on accept, iterate in CALCULO, register results when entering FIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cont   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      cociente <= '0;
      resto    <= '0;
    end else begin
      case (r_estado)
        ST_REPOSO: begin
          if (inicio) begin
            r_rem  <= '0;
            r_quo  <= w_mag_a;
            r_dvs  <= w_mag_b;
            r_cont <= '0;
            if (w_div0) begin
              cociente <= COCIENTE_DIV0;
              resto    <= dividendo;
            end
          end
        end
        ST_CALCULO: begin
          r_rem  <= w_rem_sig;
          r_quo  <= w_quo_sig;
          r_cont <= r_cont + 1'b1;
          if (w_ultimo) begin
            cociente <= w_q_fin;
            resto    <= w_r_fin;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : div_secuencial
`default_nettype wire

// File: tb/tb_div_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_secuencial
// Description : Scoreboard bench for div_secuencial. The driver pushes the
//               expected quotient/remainder, completion cycle and busy length
//               of each accepted request; a monitor pops on every listo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_secuencial;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic        con_signo;
  logic [31:0] dividendo;
  logic [31:0] divisor;
  logic        ocupado;
  logic        listo;
  logic [31:0] cociente;
  logic [31:0] resto;

  div_secuencial dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .con_signo (con_signo),
    .dividendo (dividendo),
    .divisor   (divisor),
    .ocupado   (ocupado),
    .listo     (listo),
    .cociente  (cociente),
    .resto     (resto)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          due;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   cnt_busy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RISC-V division rules in plain arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input bit sg, output logic [31:0] q,
                                output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIV_SIGNO_EN
      if (sg) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
      end
`endif
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compare every completion against the oldest expectation
  always @(negedge clk) begin
    if (reset) begin
      cnt_busy = 0;
    end else begin
      if (ocupado) cnt_busy++;
      if (listo) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_listo: got listo=1 expected no pending op (cyc %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("cociente %h/%h", e.a, e.b), cociente, e.q);
          check($sformatf("resto %h/%h", e.a, e.b), resto, e.r);
          check($sformatf("latency %h/%h", e.a, e.b), 32'(cyc), 32'(e.due));
          check($sformatf("busy_cycles %h/%h", e.a, e.b), 32'(cnt_busy), 32'(e.busy));
        end
        cnt_busy = 0;
      end
    end
  end

  // Called at a negedge with the divider idle; request is accepted next edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sg);
    exp_t e;
    model(a, b, sg, e.q, e.r);
    e.a    = a;
    e.b    = b;
    e.due  = cyc + 1 + ((b == 32'd0) ? 0 : 32);
    e.busy = (b == 32'd0) ? 0 : 32;
    sb.push_back(e);
    dividendo = a;
    divisor   = b;
    con_signo = sg;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
    dividendo = $urandom;
    divisor   = $urandom;
    con_signo = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || ocupado || listo) && n < 200);
    if (sb.size() != 0 || ocupado || listo) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d pending ops after %0d cycles, expected 0", sb.size(), n);
      sb.delete();
    end
  endtask

  logic [31:0] dir_a [12] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                             32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000,
                             32'd0, 32'd0, 32'd5, 32'hFFFF_FFF9};
  logic [31:0] dir_b [12] = '{32'd7, 32'd1, 32'h8000_0001, 32'd0,
                             32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd5, 32'd0, 32'd0, 32'd2};
  bit          dir_s [12] = '{1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset     = 1'b1;
    inicio    = 1'b0;
    con_signo = 1'b0;
    dividendo = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset_cociente", cociente, 32'd0);
    check("reset_resto", resto, 32'd0);
    check("reset_ocupado", {31'd0, ocupado}, 32'd0);
    check("reset_listo", {31'd0, listo}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    for (int i = 0; i < 12; i++) begin
      issue(dir_a[i], dir_b[i], dir_s[i]);
      wait_idle();
    end

    // Request while busy is dropped; only 1000/3 completes
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    dividendo = 32'd9;
    divisor   = 32'd3;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset in the middle of an operation discards it
    issue(32'd1000, 32'd3, 1'b0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    check("midreset_cociente", cociente, 32'd0);
    check("midreset_resto", resto, 32'd0);
    check("midreset_ocupado", {31'd0, ocupado}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("postreset_ocupado", {31'd0, ocupado}, 32'd0);
    check("postreset_listo", {31'd0, listo}, 32'd0);
    issue(32'd9, 32'd3, 1'b0);
    wait_idle();

    // Randomized operands with a mix of divisor magnitudes
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd1;
      issue(a, b, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_div_secuencial
`default_nettype wire
